// File: rtl/switch_io_pkg.sv
// Shared definitions for the switch-bank read path: MMIO addresses, FSM states, field decode.
package switch_io_pkg;

    localparam logic [7:0] SW_ADDR_LO4  = 8'h70;
    localparam logic [7:0] SW_ADDR_HI8  = 8'h74;
    localparam logic [7:0] SW_ADDR_MID8 = 8'h78;
    localparam logic [7:0] SW_ADDR_FLAG = 8'h7C;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWait,
        StCapture,
        StAck
    } sw_state_e;

    // Bits 23:21 of the switch bank are never mapped, so only 20:0 are passed in.
    function automatic logic [15:0] sw_field(input logic [7:0] addr, input logic [20:0] sw);
        logic [15:0] field;
        case (addr)
            SW_ADDR_LO4:  field = {12'h000, sw[3:0]};
            SW_ADDR_HI8:  field = {8'h00, sw[19:12]};
            SW_ADDR_MID8: field = {8'h00, sw[11:4]};
            SW_ADDR_FLAG: field = {15'h0000, sw[20]};
            default:      field = sw[15:0];
        endcase
        return field;
    endfunction

endpackage

// File: rtl/switch_read_ctrl_if.sv
// CPU-side load handshake of the switch-bank MMIO window.
interface switch_read_ctrl_if;

    logic        io_rd_req;
    logic [7:0]  io_addr;
    logic        io_rd_ack;
    logic [15:0] io_rd_data;

    modport master (
        output io_rd_req,
        output io_addr,
        input  io_rd_ack,
        input  io_rd_data
    );

    modport slave (
        input  io_rd_req,
        input  io_addr,
        output io_rd_ack,
        output io_rd_data
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and saturating counter; o_stable changes after DEBOUNCE_CYCLES
// consecutive synced samples that differ from the current stable level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);

    logic             r_s1;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_s1   <= i_btn;
            r_sync <= r_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            // This sample is the DEBOUNCE_CYCLES-th consecutive differing one.
            r_stable <= r_sync;
            r_cnt    <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/switch_read_ctrl.sv
// MMIO read sequencer for the switch bank. Define SWITCH_CONFIRM_EN to hold reads
// (except the flag address) until a debounced confirm-button press.
module switch_read_ctrl
    import switch_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic                     clk,
    input  logic                     rst,
    switch_read_ctrl_if.slave        bus,
    input  logic [23:0]              sw_in,
    input  logic                     confirm_btn,
    output logic                     busy,
    output logic                     wait_confirm
);

    sw_state_e   r_state;
    sw_state_e   w_state_next;
    logic        w_addr_load;
    logic [7:0]  r_addr;
    logic [15:0] r_data;
    logic [23:0] r_sw_s1;
    logic [23:0] r_sw_s2;
    logic        w_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= sw_in;
            r_sw_s2 <= r_sw_s1;
        end
    end

`ifdef SWITCH_CONFIRM_EN
    logic w_btn_stable;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (rst),
        .i_btn    (confirm_btn),
        .o_stable (w_btn_stable)
    );

    assign w_unused = ^r_sw_s2[23:21];
`else
    assign w_unused = ^{r_sw_s2[23:21], confirm_btn, (DEBOUNCE_CYCLES == 0)};
`endif

    always_comb begin
        w_state_next = r_state;
        w_addr_load  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.io_rd_req) begin
                    w_addr_load = 1'b1;
`ifdef SWITCH_CONFIRM_EN
                    w_state_next = (bus.io_addr == SW_ADDR_FLAG) ? StCapture : StArm;
`else
                    w_state_next = StCapture;
`endif
                end
            end
`ifdef SWITCH_CONFIRM_EN
            // A button still held from a previous read must be released before it counts.
            StArm: begin
                if (!bus.io_rd_req) w_state_next = StIdle;
                else if (!w_btn_stable) w_state_next = StWait;
            end
            StWait: begin
                if (!bus.io_rd_req) w_state_next = StIdle;
                else if (w_btn_stable) w_state_next = StCapture;
            end
`endif
            StCapture: w_state_next = StAck;
            StAck:     w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_addr_load) r_addr <= bus.io_addr;
            if (r_state == StCapture) r_data <= sw_field(r_addr, r_sw_s2[20:0]);
        end
    end

    assign bus.io_rd_ack  = (r_state == StAck);
    assign bus.io_rd_data = r_data;
    assign busy           = (r_state != StIdle);
`ifdef SWITCH_CONFIRM_EN
    assign wait_confirm   = (r_state == StArm) || (r_state == StWait);
`else
    assign wait_confirm   = 1'b0;
`endif

endmodule

// File: tb/tb_switch_read_ctrl.sv
// Directed bench for switch_read_ctrl; exercises the confirm path when SWITCH_CONFIRM_EN is set.
module tb_switch_read_ctrl;

    logic        clk;
    logic        rst;
    logic [23:0] sw_in;
    logic        confirm_btn;
    logic        busy;
    logic        wait_confirm;
    int          n_tests;
    int          n_fail;

    switch_read_ctrl_if bus ();

    switch_read_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .sw_in        (sw_in),
        .confirm_btn  (confirm_btn),
        .busy         (busy),
        .wait_confirm (wait_confirm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks n cycles, counting acks and cycles where wait_confirm differs from wc_exp.
    task automatic run_cycles(input int n, input logic wc_exp, output int acks, output int wc_bad);
        acks   = 0;
        wc_bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.io_rd_ack) acks++;
            if (wait_confirm !== wc_exp) wc_bad++;
        end
    endtask

    task automatic wait_ack(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (bus.io_rd_ack) found = 1'b1;
        end
    endtask

    // Fast-path read: accept at the next edge, ack exactly two edges after acceptance.
    task automatic fast_read(input string tag, input logic [7:0] addr, input logic [15:0] exp,
                             input logic swap_addr);
        bus.io_rd_req = 1'b1;
        bus.io_addr   = addr;
        tick();
        if (swap_addr) bus.io_addr = 8'h40;
        check_eq({tag, "_busy1"}, busy, 1);
        check_eq({tag, "_ack1"}, bus.io_rd_ack, 0);
        check_eq({tag, "_wc1"}, wait_confirm, 0);
        tick();
        check_eq({tag, "_ack2"}, bus.io_rd_ack, 1);
        check_eq({tag, "_busy2"}, busy, 1);
        check_eq({tag, "_data"}, bus.io_rd_data, exp);
        bus.io_rd_req = 1'b0;
        tick();
        check_eq({tag, "_ack3"}, bus.io_rd_ack, 0);
        check_eq({tag, "_busy3"}, busy, 0);
    endtask

    initial begin
        int   acks;
        int   wc_bad;
        logic found;

        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        sw_in         = 24'h1A5C3F;
        confirm_btn   = 1'b0;
        bus.io_rd_req = 1'b0;
        bus.io_addr   = 8'h00;
        #12;
        check_eq("rst_ack", bus.io_rd_ack, 0);
        check_eq("rst_data", bus.io_rd_data, 16'h0000);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wc", wait_confirm, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

`ifndef SWITCH_CONFIRM_EN
        fast_read("lo4", 8'h70, 16'h000F, 1'b0);
        fast_read("hi8", 8'h74, 16'h00A5, 1'b0);
        fast_read("mid8", 8'h78, 16'h00C3, 1'b0);
        fast_read("flag", 8'h7C, 16'h0001, 1'b0);
        fast_read("other", 8'h40, 16'h5C3F, 1'b0);
        fast_read("addr_ignored", 8'h70, 16'h000F, 1'b1);
        sw_in = 24'h123456;
        tick();
        tick();
        fast_read("mid8_b", 8'h78, 16'h0045, 1'b0);
        fast_read("lo4_b", 8'h70, 16'h0006, 1'b0);
        sw_in = 24'hE00000;
        tick();
        tick();
        fast_read("flag_b", 8'h7C, 16'h0000, 1'b0);
`else
        // Button held before the request: read must park in ARM.
        confirm_btn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.io_rd_req = 1'b1;
        bus.io_addr   = 8'h74;
        run_cycles(12, 1'b1, acks, wc_bad);
        check_eq("held_noack", acks, 0);
        check_eq("held_wc", wc_bad, 0);
        check_eq("held_busy", busy, 1);
        confirm_btn = 1'b0;
        run_cycles(10, 1'b1, acks, wc_bad);
        check_eq("release_noack", acks, 0);
        check_eq("release_wc", wc_bad, 0);
        sw_in = 24'h0AB000;
        tick();
        tick();
        confirm_btn = 1'b1;
        wait_ack(20, found);
        check_eq("press_ack", found, 1);
        check_eq("press_data", bus.io_rd_data, 16'h00AB);
        bus.io_rd_req = 1'b0;
        run_cycles(6, 1'b0, acks, wc_bad);
        check_eq("press_once", acks, 0);
        check_eq("press_busy", busy, 0);
        confirm_btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Three-cycle glitch in WAIT must not confirm; four stable cycles must.
        sw_in = 24'h1A5C3F;
        bus.io_rd_req = 1'b1;
        bus.io_addr   = 8'h78;
        run_cycles(4, 1'b1, acks, wc_bad);
        confirm_btn = 1'b1;
        tick();
        tick();
        tick();
        confirm_btn = 1'b0;
        run_cycles(10, 1'b1, acks, wc_bad);
        check_eq("glitch_noack", acks, 0);
        check_eq("glitch_wc", wc_bad, 0);
        confirm_btn = 1'b1;
        wait_ack(20, found);
        check_eq("stable_ack", found, 1);
        check_eq("stable_data", bus.io_rd_data, 16'h00C3);
        bus.io_rd_req = 1'b0;
        confirm_btn   = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        fast_read("flag_fast", 8'h7C, 16'h0001, 1'b0);

        // Request withdrawn in WAIT: abort, data untouched.
        bus.io_rd_req = 1'b1;
        bus.io_addr   = 8'h70;
        run_cycles(4, 1'b1, acks, wc_bad);
        check_eq("abort_wc_before", wc_bad, 0);
        bus.io_rd_req = 1'b0;
        tick();
        check_eq("abort_busy", busy, 0);
        check_eq("abort_wc", wait_confirm, 0);
        run_cycles(6, 1'b0, acks, wc_bad);
        check_eq("abort_noack", acks, 0);
        check_eq("abort_data", bus.io_rd_data, 16'h0001);

        // Reset while in WAIT.
        bus.io_rd_req = 1'b1;
        bus.io_addr   = 8'h70;
        run_cycles(4, 1'b1, acks, wc_bad);
        #2 rst = 1'b1;
        #1;
        check_eq("rstwait_busy", busy, 0);
        check_eq("rstwait_wc", wait_confirm, 0);
        check_eq("rstwait_data", bus.io_rd_data, 16'h0000);
        bus.io_rd_req = 1'b0;
        tick();
        rst = 1'b0;
        run_cycles(6, 1'b0, acks, wc_bad);
        check_eq("rstwait_noack", acks, 0);
`endif

        // Reset between acceptance and capture: no ack, data back to zero.
        for (int i = 0; i < 4; i++) tick();
        bus.io_rd_req = 1'b1;
        bus.io_addr   = 8'h7C;
        tick();
        check_eq("rstcap_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("rstcap_busy", busy, 0);
        check_eq("rstcap_ack", bus.io_rd_ack, 0);
        check_eq("rstcap_data", bus.io_rd_data, 16'h0000);
        bus.io_rd_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_eq("rstcap_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_read_ctrl.md
# switch_read_ctrl

Sequencer for CPU memory-mapped reads of the board switch bank. It sits between the load path of the MMIO bus (addresses 0x70–0x7C) and the raw switch/button pins. It accepts a read request, optionally holds the CPU until the user confirms input with a debounced button press, then captures and returns the decoded switch field with a one-cycle acknowledge.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 20000, consecutive equal button samples required to change the stable level; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- io_rd_req  in  1  level read request; held until io_rd_ack seen.
- io_addr  in  8  MMIO byte address; sampled when a request is accepted.
- sw_in  in  24  raw switch pins, asynchronous.
- confirm_btn  in  1  raw confirm button, asynchronous, active-high.
- io_rd_ack  out  1  one-cycle pulse; io_rd_data valid in that cycle.
- io_rd_data  out  16  decoded switch field; holds until next capture.
- busy  out  1  high while a transaction is in flight; drives the CPU stall.
- wait_confirm  out  1  high while waiting for a button press; drives the board LED.

## Operation
- Synchronise sw_in and confirm_btn through 2 flops each, reset 0.
- Field map, applied at capture to synced switches:
  - 0x70 → {12'h000, sw[3:0]}
  - 0x74 → {8'h00, sw[19:12]}
  - 0x78 → {8'h00, sw[11:4]}
  - 0x7C → {15'h0000, sw[20]}
  - any other → sw[15:0]
- FSM states: IDLE, ARM, WAIT, CAPTURE, ACK.
  - IDLE: when io_rd_req=1, latch io_addr. Go to ARM, or to CAPTURE if confirm is disabled or the address is 0x7C.
  - ARM: wait until the debounced button is stable 0, so a held button cannot satisfy a new read. Then go to WAIT.
  - WAIT: wait until the debounced button is stable 1, then go to CAPTURE.
  - CAPTURE: register the field into io_rd_data, go to ACK.
  - ACK: io_rd_ack=1 for this one cycle, then go to IDLE.
- io_addr changes after acceptance are ignored.
- io_rd_req dropping in ARM or WAIT aborts to IDLE with no ack. io_rd_data is unchanged.
- A req still high on the edge leaving ACK starts a new transaction on the next IDLE cycle; there is no same-cycle re-accept.
- busy = (state ≠ IDLE). wait_confirm = (state ∈ {ARM, WAIT}).
- Debouncer counter is $clog2(DEBOUNCE_CYCLES+1) bits, saturating.
  - Counter clears whenever the synced sample equals the current stable level.
  - Stable level flips when the counter reaches DEBOUNCE_CYCLES.

## Timing
- Reset values: io_rd_ack=0, io_rd_data=16'h0000, busy=0, wait_confirm=0, state IDLE, stable button 0, counter 0.
- Fast path (0x7C, or confirm disabled): req sampled at edge k → CAPTURE. Data registered at k+1, ack high k+1..k+2. IDLE at k+2.
- Confirm path: ARM exits ≥ DEBOUNCE_CYCLES cycles after the synced button goes low. WAIT exits DEBOUNCE_CYCLES cycles after the synced button goes high and stays high. Ack follows 2 edges after leaving WAIT.
- Data reflects switches 2 cycles of synchroniser delay before the CAPTURE edge.
- rst mid-transaction: immediate return to IDLE, all outputs to reset values, no ack.

## Configuration
- SWITCH_CONFIRM_EN defined: ARM/WAIT path and the debouncer are present; every address except 0x7C waits for a confirm press.
- SWITCH_CONFIRM_EN undefined: all addresses take the fast path. Debouncer, ARM and WAIT are removed. wait_confirm is tied 0, and confirm_btn is unused.

## Structure
- Shared package switch_io_pkg holds:
  - address constants SW_ADDR_LO4=8'h70, SW_ADDR_HI8=8'h74, SW_ADDR_MID8=8'h78, SW_ADDR_FLAG=8'h7C;
  - state enum for the FSM.
- One sub-module, btn_debounce: synchroniser plus counter. Output is the stable level. Instantiated only under SWITCH_CONFIRM_EN.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- No macro: sw_in=24'h1A5C3F, req@0x70 → ack exactly 2 cycles after acceptance, data=16'h000F; busy high for 2 cycles.
- No macro: same switches, reads of 0x74/0x78/0x7C/0x40 → 16'h00A5, 16'h00C3, 16'h0001, 16'h5C3F.
- Macro on: req@0x74, button already held high → stays in ARM, no ack. Release ≥4 cycles, press ≥4 cycles → ack once, data from switches at press time; wait_confirm high throughout.
- Macro on: button glitch high for 3 cycles in WAIT → no ack. Stable 4 cycles → ack.
- Macro on: req@0x7C with button idle → fast-path ack in 2 cycles, wait_confirm stays 0.
- Macro on: req dropped in WAIT, or rst asserted in WAIT → IDLE, no ack, io_rd_data keeps its previous value on abort and is 0 after rst.
